writeback_stage: RTL and testbench

Final (WB) stage of the 5-stage core: registers the MEM/WB pipeline payload, formats load data by size, signedness and byte offset, and selects the result source. It drives the register-file write port of instruction decode (`write_data`, `reg_write`, `write_reg_num`), i.e. the writer side of the decode stage's register reads. It also exposes WB-stage forwarding info and an optional retire counter.

---
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM/WB payload, formats loads, drives the regfile write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_wb_valid,
  input  logic            wb_stall,
  input  logic            wb_flush,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] mem_read_data_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic            mem_to_reg_in,
  input  logic            link_in,
  input  logic [1:0]      mem_size_in,
  input  logic            is_unsigned_in,
  input  logic            reg_write_in,
  input  logic [4:0]      rd_in,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write,
  output logic [4:0]      write_reg_num,
  output logic            wb_valid,
  output logic            misalign_err,
  output logic [63:0]     instret
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem;
    logic [XLEN-1:0] pc4;
    logic            m2r;
    logic            link;
    logic [1:0]      size;
    logic            uns;
    logic            rw;
    logic [4:0]      rd;
  } wb_pay_t;

  wb_pay_t pay_q, pay_d;
  logic    load_en;

  logic [1:0]      off;
  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] load_v;
  logic            retire;

  assign load_en = mem_wb_valid & ~wb_stall & ~wb_flush;

  // Next payload: stall or flush turns the slot into a bubble.
  always_comb begin
    pay_d       = '0;
    pay_d.valid = load_en;
    pay_d.alu   = alu_result_in;
    pay_d.mem   = mem_read_data_in;
    pay_d.pc4   = pc_plus_4_in;
    pay_d.m2r   = mem_to_reg_in;
    pay_d.link  = link_in;
    pay_d.size  = mem_size_in;
    pay_d.uns   = is_unsigned_in;
    pay_d.rw    = reg_write_in & load_en;
    pay_d.rd    = rd_in;
  end

  // Stage register, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pay_q <= '0;
    end else begin
      pay_q <= pay_d;
    end
  end

  assign off = pay_q.alu[1:0];

  // Load formatting: pick byte/half by offset, then extend.
  always_comb begin
    shifted = pay_q.mem >> {off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off[1] ? pay_q.mem[31:16] : pay_q.mem[15:0];
    load_v  = pay_q.mem;
    case (pay_q.size)
      2'b00: begin
        if (pay_q.uns) load_v = {{(XLEN-8){1'b0}}, byte_v};
        else           load_v = {{(XLEN-8){byte_v[7]}}, byte_v};
      end
      2'b01: begin
        if (pay_q.uns) load_v = {{(XLEN-16){1'b0}}, half_v};
        else           load_v = {{(XLEN-16){half_v[15]}}, half_v};
      end
      default: load_v = pay_q.mem;
    endcase
  end

  // Fault detection on loads, then result mux and write enable.
  always_comb begin
    misalign_err = 1'b0;
    if (pay_q.valid && pay_q.m2r) begin
      unique case (1'b1)
        pay_q.size == 2'b01: misalign_err = off[0];
        pay_q.size == 2'b10: misalign_err = off != 2'b00;
        pay_q.size == 2'b11: misalign_err = 1'b1;
        default:             misalign_err = 1'b0;
      endcase
    end
    if (pay_q.link)     write_data = pay_q.pc4;
    else if (pay_q.m2r) write_data = load_v;
    else                write_data = pay_q.alu;
    reg_write = pay_q.valid & pay_q.rw
              & (pay_q.rd != 5'd0) & ~misalign_err;
    retire    = pay_q.valid & ~misalign_err;
  end

  assign write_reg_num = pay_q.rd;
  assign wb_valid      = pay_q.valid;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q, instret_d;

  // Count retired instructions; wraps naturally at 2^64.
  always_comb instret_d = instret_q + {63'd0, retire};

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed cases then random traffic.
// Expected results come from a behavioural model of load formatting and write rules.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_wb_valid = 1'b0;
  logic        wb_stall = 1'b0;
  logic        wb_flush = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] mem_read_data_in = '0;
  logic [31:0] pc_plus_4_in = '0;
  logic        mem_to_reg_in = 1'b0;
  logic        link_in = 1'b0;
  logic [1:0]  mem_size_in = '0;
  logic        is_unsigned_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic [31:0] write_data;
  logic        reg_write;
  logic [4:0]  write_reg_num;
  logic        wb_valid;
  logic        misalign_err;
  logic [63:0] instret;

  writeback_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .mem_wb_valid(mem_wb_valid), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .alu_result_in(alu_result_in), .mem_read_data_in(mem_read_data_in),
    .pc_plus_4_in(pc_plus_4_in), .mem_to_reg_in(mem_to_reg_in),
    .link_in(link_in), .mem_size_in(mem_size_in),
    .is_unsigned_in(is_unsigned_in), .reg_write_in(reg_write_in),
    .rd_in(rd_in), .write_data(write_data), .reg_write(reg_write),
    .write_reg_num(write_reg_num), .wb_valid(wb_valid),
    .misalign_err(misalign_err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    bit          chkdata;
    bit          we;
    logic [4:0]  rd;
    bit          mis;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  logic        rst_edge = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mret = '0;
  bit          started = 0;
  bit          done = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] alu, mem, pc4,
                                 input bit m2r, lnk,
                                 input logic [1:0] sz,
                                 input bit uns, rw,
                                 input logic [4:0] rd);
    exp_t        e;
    int unsigned off;
    logic [31:0] part;
    logic [31:0] ld;
    off   = alu % 4;
    e.mis = m2r && (sz == 2'd3 || (sz == 2'd1 && off % 2 == 1)
                    || (sz == 2'd2 && off != 0));
    ld = mem;
    if (sz == 2'd0) begin
      part = (mem >> (8 * off)) & 32'hFF;
      ld   = (!uns && part >= 128) ? part + 32'hFFFF_FF00 : part;
    end else if (sz == 2'd1) begin
      part = (mem >> (8 * off)) & 32'hFFFF;
      ld   = (!uns && part >= 32768) ? part + 32'hFFFF_0000 : part;
    end
    if (lnk)      e.data = pc4;
    else if (m2r) e.data = ld;
    else          e.data = alu;
    e.chkdata = lnk || !e.mis;
    e.we      = rw && rd != 0 && !e.mis;
    e.rd      = rd;
    e.due     = 0;
    return e;
  endfunction

  task automatic drive(input bit r, v, st, fl,
                       input logic [31:0] alu, mem, pc4,
                       input bit m2r, lnk,
                       input logic [1:0] sz,
                       input bit uns, rw,
                       input logic [4:0] rd);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    mem_wb_valid     = v;
    wb_stall         = st;
    wb_flush         = fl;
    alu_result_in    = alu;
    mem_read_data_in = mem;
    pc_plus_4_in     = pc4;
    mem_to_reg_in    = m2r;
    link_in          = lnk;
    mem_size_in      = sz;
    is_unsigned_in   = uns;
    reg_write_in     = rw;
    rd_in            = rd;
    if (r && v && !st && !fl) begin
      e     = model(alu, mem, pc4, m2r, lnk, sz, uns, rw, rd);
      e.due = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit r);
    drive(r, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 2'd0, 0, 0, 5'd0);
  endtask

  // Monitor: compares WB outputs against the scoreboard each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_edge === 1'b0) begin
        started = 1;
        mret    = '0;
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
        chk("rst_write_data", {32'd0, write_data}, 64'd0);
        chk("rst_write_reg_num", {59'd0, write_reg_num}, 64'd0);
        chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
        chk("rst_instret", instret, 64'd0);
      end else if (started) begin
`ifdef WB_RETIRE_CNT_EN
        chk("instret", instret, mret);
`else
        chk("instret_tied", instret, 64'd0);
`endif
        while (q.size() > 0 && q[0].due < cyc) begin
          e = q.pop_front();
          chk("missed_instr", 64'd0, {59'd0, e.rd});
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("wb_valid", {63'd0, wb_valid}, 64'd1);
          chk("reg_write", {63'd0, reg_write}, {63'd0, e.we});
          chk("write_reg_num", {59'd0, write_reg_num}, {59'd0, e.rd});
          chk("misalign_err", {63'd0, misalign_err}, {63'd0, e.mis});
          if (e.chkdata)
            chk("write_data", {32'd0, write_data}, {32'd0, e.data});
          if (!e.mis) mret = mret + 64'd1;
        end else begin
          chk("bubble_valid", {63'd0, wb_valid}, 64'd0);
          chk("bubble_reg_write", {63'd0, reg_write}, 64'd0);
          chk("bubble_misalign", {63'd0, misalign_err}, 64'd0);
        end
      end
    end
  end

  // Stimulus: directed cases from the plan, then random traffic.
  initial begin
    int wait_cyc;
    rst = 1'b0;
    idle(0);
    idle(0);
    idle(1);
    idle(1);
    // lb / lbu / lhu
    drive(1, 1, 0, 0, 32'h3, 32'h80FF_7F01, 32'h0, 1, 0, 2'd0, 0, 1, 5'd5);
    drive(1, 1, 0, 0, 32'h3, 32'h80FF_7F01, 32'h0, 1, 0, 2'd0, 1, 1, 5'd6);
    drive(1, 1, 0, 0, 32'h2, 32'h80FF_7F01, 32'h0, 1, 0, 2'd1, 1, 1, 5'd7);
    // jal rd=1, addi rd=0
    drive(1, 1, 0, 0, 32'h1234, 32'h0, 32'h30, 0, 1, 2'd2, 0, 1, 5'd1);
    drive(1, 1, 0, 0, 32'h55, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd0);
    // lw off=2, lh off=1
    drive(1, 1, 0, 0, 32'h2, 32'hDEAD_BEEF, 32'h0, 1, 0, 2'd2, 0, 1, 5'd8);
    drive(1, 1, 0, 0, 32'h1, 32'hDEAD_BEEF, 32'h0, 1, 0, 2'd1, 0, 1, 5'd9);
    // three ALU ops with a one-cycle stall after the first
    drive(1, 1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd10);
    drive(1, 1, 1, 0, 32'h11, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd11);
    drive(1, 1, 0, 0, 32'h11, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd11);
    drive(1, 1, 0, 0, 32'h12, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd12);
    // flush on a valid input
    drive(1, 1, 0, 1, 32'h13, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd13);
    // reset while streaming, then resume
    drive(1, 1, 0, 0, 32'h14, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd14);
    drive(0, 1, 0, 0, 32'h15, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd15);
    drive(1, 1, 0, 0, 32'h16, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd16);
    drive(1, 1, 0, 0, 32'h17, 32'h0, 32'h0, 0, 0, 2'd2, 0, 1, 5'd17);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 60) != 0,
            ($urandom % 4) != 0,
            ($urandom % 8) == 0,
            ($urandom % 10) == 0,
            $urandom, $urandom, $urandom,
            ($urandom % 2) == 1,
            ($urandom % 6) == 0,
            2'($urandom % 4),
            ($urandom % 2) == 1,
            ($urandom % 5) != 0,
            5'($urandom % 32));
    end
    idle(1);
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      idle(1);
      wait_cyc++;
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
